// File: rtl/data_lsu_pkg.sv
// Shared encodings for the data load/store unit: control levels, access
// sizes, exception causes and FSM states.
package data_lsu_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Size 2'b11 behaves as a word access everywhere in the unit.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return addr_lo[0];
      default:  return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/data_lsu_align.sv
// Byte-lane steering for stores and little-endian extract/extend for loads.
// Purely combinational; shared by the request-capture and load-capture paths.
module lsu_align
  import data_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  sel,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  // Aligned words have addr_lo == 0, so the shift leaves them untouched.
  assign shifted = ld_raw >> {addr_lo, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    sel      = 4'b1111;
    st_lanes = st_data;
    ld_data  = shifted;
    case (size)
      MEM_BYTE: begin
        sel      = 4'b0001 << addr_lo;
        st_lanes = {4{st_data[7:0]}};
        ld_data  = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      MEM_HALF: begin
        sel      = 4'b0011 << addr_lo;
        st_lanes = {2{st_data[15:0]}};
        ld_data  = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_lsu.sv
// Load/store unit between the MEM stage and the data RAM: one request per
// instruction, IDLE -> ACCESS -> RESP, with misaligned requests skipping ACCESS.
module data_lsu
  import data_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall_req,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              exc_valid,
  output logic [3:0]        exc_cause,
  output logic [ADDR_W-1:0] exc_tval,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  lsu_state_e state, state_next;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_exc;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_sel;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              in_idle;
  logic              accept;
  logic              req_mis;
  logic [1:0]        al_size;
  logic [1:0]        al_addr_lo;
  logic [3:0]        al_sel;
  logic [DATA_W-1:0] al_lanes;
  logic [DATA_W-1:0] al_ld;

  assign in_idle = (state == ST_IDLE);
  assign accept  = in_idle & req_valid & ~flush;
  assign req_mis = is_misaligned(req_size, req_addr[1:0]);

  // In IDLE the aligner steers the incoming store; afterwards it extracts
  // the load from the registered request.
  assign al_size    = in_idle ? req_size       : r_size;
  assign al_addr_lo = in_idle ? req_addr[1:0]  : r_addr[1:0];

  lsu_align u_align (
    .size        (al_size),
    .addr_lo     (al_addr_lo),
    .is_unsigned (r_unsigned),
    .st_data     (req_wdata),
    .ld_raw      (ram_rdata),
    .sel         (al_sel),
    .st_lanes    (al_lanes),
    .ld_data     (al_ld)
  );

  always_comb begin
    state_next = state;
    stall_req  = 1'b0;
    resp_valid = 1'b0;
    ram_ce     = CHIP_DISABLE;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          stall_req  = 1'b1;
          state_next = req_mis ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ram_ce     = ~flush;
        stall_req  = ~flush;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = ~flush;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // RAM-side outputs are forced to zero whenever the chip is not enabled.
  assign ram_we    = ram_ce & r_we;
  assign ram_addr  = ram_ce ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign ram_sel   = ram_ce ? r_sel   : 4'b0000;
  assign ram_wdata = ram_ce ? r_wdata : '0;

  assign rdata     = resp_valid ? r_rdata : '0;
  assign exc_valid = resp_valid & r_exc;
  assign exc_cause = exc_valid ? (r_we ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN) : 4'd0;
  assign exc_tval  = exc_valid ? r_addr : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state      <= ST_IDLE;
      r_we       <= 1'b0;
      r_size     <= MEM_BYTE;
      r_unsigned <= 1'b0;
      r_exc      <= 1'b0;
      r_addr     <= '0;
      r_sel      <= 4'b0000;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        r_we       <= req_we;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_exc      <= req_mis;
        r_addr     <= req_addr;
        r_sel      <= al_sel;
        r_wdata    <= (req_we == WRITE_ENABLE) ? al_lanes : '0;
        r_rdata    <= '0;
      end else if (state == ST_ACCESS && !flush && !r_we) begin
        r_rdata <= al_ld;
      end
    end
  end

endmodule

// File: doc/data_lsu.md
Name: data_lsu

Overview:
- Load/store unit between the MEM pipeline stage and the data RAM.
- Takes one memory request per instruction and generates the RAM chip-enable, write-enable, word address, byte selects and lane-steered write data.
- Aligns and sign/zero-extends load data, and raises load/store address-misaligned exceptions toward exception handling.
- Holds the pipeline via stall_req until the access completes.

Parameters:
- ADDR_W, 32, byte-address width of requests and RAM address.
- DATA_W, 32, data width; fixed at 32, since lane logic assumes 4 bytes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush from exception control; synchronous.
- req_valid  in  1  MEM stage has a memory instruction.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned  in  1  load zero-extends (LBU/LHU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- stall_req  out  1  hold the MEM stage and everything upstream.
- resp_valid  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  extended load result, valid with resp_valid.
- exc_valid  out  1  misaligned exception, valid with resp_valid.
- exc_cause  out  4  4 = load misaligned, 6 = store misaligned.
- exc_tval  out  ADDR_W  faulting address.
- ram_ce  out  1  RAM chip enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  word address: req_addr with bits [1:0] forced to 0.
- ram_sel  out  4  byte-lane enables; sel[i] covers data[8i+7:8i].
- ram_wdata  out  DATA_W  lane-replicated store data.
- ram_rdata  in  DATA_W  RAM read data, combinational from ce/addr.

Behaviour:
- Reset: state goes to IDLE. All outputs are 0: stall_req, resp_valid, rdata, exc_*, ram_ce, ram_we, ram_sel, ram_addr, ram_wdata.
- FSM states: IDLE, ACCESS, RESP.
- Misalignment:
  - half: addr[0] != 0.
  - word: addr[1:0] != 0.
  - byte: never misaligned.
- IDLE:
  - If req_valid and not flush: register the request and set stall_req = 1 (combinational, this cycle).
  - Aligned request goes to ACCESS.
  - Misaligned request goes to RESP with the exception registered.
  - If req_valid is low, stall_req = 0.
- ACCESS:
  - ram_ce = 1 and ram_we = stored we; both are gated by ~flush, so a flushed store never writes.
  - ram_addr, ram_sel and ram_wdata come from registers.
  - A load captures the extracted/extended ram_rdata into rdata at the edge.
  - stall_req = 1; next state is RESP.
- RESP:
  - resp_valid = 1 and stall_req = 0, so the MEM stage advances at this edge.
  - req_valid is ignored in this state.
  - Next state is IDLE.
- Latency:
  - Aligned op: 3 cycles (accept, access, respond). A store commits at the end of ACCESS.
  - Misaligned op: 2 cycles, with no RAM access.
- Store lanes:
  - SB: sel = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: sel = 0011 << addr[1:0]; wdata = half replicated ×2.
  - SW: sel = 1111.
- Load extract (little-endian):
  - byte = ram_rdata >> (8 × addr[1:0]); half uses the same shift.
  - Sign-extend unless req_unsigned.
  - Word loads pass through unchanged.
- Exceptions:
  - exc_valid and resp_valid assert together in RESP.
  - exc_tval = the original byte address.
  - rdata = 0 on an exception.
- For stores, rdata = 0.
- ram_sel, ram_we, ram_addr and ram_wdata are 0 whenever ram_ce = 0.
- flush in any state: next state is IDLE, with no resp_valid and stall_req = 0 that cycle. flush beats a simultaneous req_valid in IDLE.
- rst mid-operation: immediate return to IDLE and all outputs cleared; any pending store is dropped.

Decomposition:
- defines.v holds:
  - `RstEnable, `ChipEnable, `ChipDisable, `WriteEnable.
  - Size encodings `MemByte, `MemHalf, `MemWord.
  - Cause codes `ExcLoadMisalign (4) and `ExcStoreMisalign (6).
  - FSM state encodings.
- One combinational sub-module, lsu_align: store sel/wdata steering and load extract/extend, shared by the ACCESS and capture paths.

Test Plan:
- SW 0xDEADBEEF at 0x100 → ACCESS cycle shows ram_ce=1, we=1, addr=0x100, sel=1111, wdata=0xDEADBEEF. stall_req is 1,1,0 over the 3 cycles, and resp_valid pulses once.
- SB 0x5A at 0x103 → sel=1000, wdata=0x5A5A5A5A. A later LB 0x103 with ram_rdata=0x80FF0000 gives rdata=0xFFFFFF80; LBU gives 0x00000080.
- LH at 0x202 with ram_rdata=0x8001_1234 → rdata=0xFFFF8001. LHU at 0x200 → 0x00001234.
- LW at 0x105 → no ram_ce; resp_valid & exc_valid in cycle 2 with exc_cause=4 and exc_tval=0x105. SH at 0x301 → cause 6, and no write occurs.
- SW with flush asserted during ACCESS → ram_ce stays 0, state returns to IDLE, no resp_valid, and RAM contents are unchanged.
- rst asserted during ACCESS of a load → the next cycle shows all outputs 0 and state IDLE. A new LW 0x0 afterwards completes normally in 3 cycles.
